// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer for the MIPS-style datapath: fetch handshake,
// R-type/NOP/HALT decode, execute and writeback strobes, error and retire tracking.
module cpu_sequencer #(
  parameter int FETCH_TMO = 15,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      instr,
  input  logic             imem_ready,
  output logic             imem_req,
  output logic             ir_load,
  output logic [4:0]       rs_addr,
  output logic [4:0]       rt_addr,
  output logic [4:0]       rd_addr,
  output logic             rf_en,
  output logic             rf_we,
  output logic [1:0]       alu_func,
  output logic             pc_en,
  output logic             busy,
  output logic             halted,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  localparam logic [7:0]       TMO_LAST  = 8'(FETCH_TMO - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [1:0]       ERR_NONE  = 2'b00;
  localparam logic [1:0]       ERR_ILL   = 2'b01;
  localparam logic [1:0]       ERR_TMO   = 2'b10;

  state_t           state_r;
  state_t           state_s;
  logic [7:0]       tmr_r;
  logic [31:0]      ir_r;
  logic             nop_r;
  logic [4:0]       rs_r;
  logic [4:0]       rt_r;
  logic [4:0]       rd_r;
  logic [1:0]       alu_func_r;
  logic [1:0]       err_code_r;
  logic [CNT_W-1:0] count_r;

  logic [5:0]       opcode_s;
  logic [5:0]       funct_s;
  logic             is_nop_s;
  logic             is_halt_s;
  logic             funct_ok_s;
  logic [1:0]       func_sel_s;

  assign opcode_s  = ir_r[31:26];
  assign funct_s   = ir_r[5:0];
  assign is_nop_s  = (ir_r == 32'h0000_0000);
  assign is_halt_s = (opcode_s == 6'h3F);

  // Map supported R-type funct codes onto the ALU operation select.
  always_comb begin
    funct_ok_s = 1'b0;
    func_sel_s = 2'b00;
    case (funct_s)
      6'h20: begin funct_ok_s = 1'b1; func_sel_s = 2'b00; end
      6'h22: begin funct_ok_s = 1'b1; func_sel_s = 2'b01; end
      6'h24: begin funct_ok_s = 1'b1; func_sel_s = 2'b10; end
      6'h25: begin funct_ok_s = 1'b1; func_sel_s = 2'b11; end
      default: begin funct_ok_s = 1'b0; func_sel_s = 2'b00; end
    endcase
  end

  // Next-state logic; a ready on the timeout cycle still completes the fetch.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) state_s = S_FETCH;
        else       state_s = S_IDLE;
      end
      S_FETCH: begin
        if (imem_ready)             state_s = S_DECODE;
        else if (tmr_r == TMO_LAST) state_s = S_ERR;
        else                        state_s = S_FETCH;
      end
      S_DECODE: begin
        if (is_nop_s)                                 state_s = S_WB;
        else if (is_halt_s)                           state_s = S_HALT;
        else if ((opcode_s == 6'h00) && funct_ok_s)   state_s = S_EXEC;
        else                                          state_s = S_ERR;
      end
      S_EXEC:  state_s = S_WB;
      S_WB:    state_s = S_FETCH;
      S_HALT:  state_s = S_HALT;
      S_ERR:   state_s = S_ERR;
      default: state_s = S_ERR;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= S_IDLE;
    else      state_r <= state_s;
  end

  // FETCH wait timer, cleared whenever the FSM is not staying in FETCH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmr_r <= 8'd0;
    end else if ((state_r == S_FETCH) && (state_s == S_FETCH)) begin
      tmr_r <= tmr_r + 8'd1;
    end else begin
      tmr_r <= 8'd0;
    end
  end

  // Instruction register and operand addresses, captured on the ir_load edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir_r <= 32'h0000_0000;
      rs_r <= 5'd0;
      rt_r <= 5'd0;
      rd_r <= 5'd0;
    end else if (ir_load) begin
      ir_r <= instr;
      rs_r <= instr[25:21];
      rt_r <= instr[20:16];
      rd_r <= instr[15:11];
    end else begin
      ir_r <= ir_r;
      rs_r <= rs_r;
      rt_r <= rt_r;
      rd_r <= rd_r;
    end
  end

  // Decode results held through EXEC/WB.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_func_r <= 2'b00;
      nop_r      <= 1'b0;
    end else if (state_r == S_DECODE) begin
      nop_r <= is_nop_s;
      if (state_s == S_EXEC) alu_func_r <= func_sel_s;
      else                   alu_func_r <= alu_func_r;
    end else begin
      alu_func_r <= alu_func_r;
      nop_r      <= nop_r;
    end
  end

  // Sticky error code, written on the transition into ERR.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_code_r <= ERR_NONE;
    end else if ((state_r == S_FETCH) && (state_s == S_ERR)) begin
      err_code_r <= ERR_TMO;
    end else if ((state_r == S_DECODE) && (state_s == S_ERR)) begin
      err_code_r <= ERR_ILL;
    end else begin
      err_code_r <= err_code_r;
    end
  end

  // Saturating retired-instruction counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= '0;
    end else if ((state_r == S_WB) && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  // Strobes decoded from the state register; ir_load follows the handshake directly.
  always_comb begin
    imem_req = 1'b0;
    ir_load  = 1'b0;
    rf_en    = 1'b0;
    rf_we    = 1'b0;
    pc_en    = 1'b0;
    busy     = 1'b0;
    halted   = 1'b0;
    case (state_r)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_load  = imem_ready;
        busy     = 1'b1;
      end
      S_DECODE: busy = 1'b1;
      S_EXEC: begin
        rf_en = 1'b1;
        busy  = 1'b1;
      end
      S_WB: begin
        pc_en = 1'b1;
        rf_we = (!nop_r) && (rd_r != 5'd0);
        busy  = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      S_IDLE:  busy   = 1'b0;
      S_ERR:   busy   = 1'b0;
      default: busy   = 1'b0;
    endcase
  end

  assign rs_addr     = rs_r;
  assign rt_addr     = rt_r;
  assign rd_addr     = rd_r;
  assign alu_func    = alu_func_r;
  assign err_code    = err_code_r;
  assign instr_count = count_r;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: expected strobe events are queued with
// their cycle numbers, a negedge monitor pops and compares them.
module tb_cpu_sequencer;

  localparam int CW = 2;
  localparam int K_LOAD = 1, K_EXEC = 2, K_WB = 3, K_HALT = 4, K_ERR = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   instr;
  logic          imem_ready = 1'b0;
  logic          imem_req, ir_load, rf_en, rf_we, pc_en, busy, halted;
  logic [4:0]    rs_addr, rt_addr, rd_addr;
  logic [1:0]    alu_func, err_code;
  logic [CW-1:0] instr_count;

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] prog [0:7];
  logic [2:0]  ptr;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  logic        halt_q = 1'b0;
  logic [1:0]  err_q = 2'b00;

  cpu_sequencer #(.FETCH_TMO(15), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .instr(instr), .imem_ready(imem_ready),
    .imem_req(imem_req), .ir_load(ir_load), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rd_addr(rd_addr), .rf_en(rf_en), .rf_we(rf_we), .alu_func(alu_func),
    .pc_en(pc_en), .busy(busy), .halted(halted), .err_code(err_code),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign instr = prog[ptr];
  always @(posedge clk or negedge rst) begin
    if (!rst)         ptr <= 3'd0;
    else if (ir_load) ptr <= ptr + 3'd1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pop_check(input int kind, input logic [31:0] val, input string name);
    exp_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL %s: unexpected event val=%0h at cycle %0d, nothing expected", name, val, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.val !== val) begin
        n_errors++;
        $display("FAIL %s: got kind=%0d cyc=%0d val=%0h expected kind=%0d cyc=%0d val=%0h",
                 name, kind, cyc, val, e.kind, e.cyc, e.val);
      end
    end
  endtask

  // Monitor: every strobe event must match the head of the expectation queue.
  always @(negedge clk) begin
    if (!rst) begin
      halt_q = 1'b0;
      err_q  = 2'b00;
    end else begin
      if (ir_load) pop_check(K_LOAD, 32'd0, "ir_load");
      if (rf_en) pop_check(K_EXEC, {15'd0, alu_func, rs_addr, rt_addr, rd_addr}, "exec");
      if (pc_en || rf_we) pop_check(K_WB, {30'd0, pc_en, rf_we}, "wb");
      if (halted && !halt_q) pop_check(K_HALT, 32'd0, "halt");
      if (err_code != 2'b00 && err_q == 2'b00) pop_check(K_ERR, {30'd0, err_code}, "err");
      halt_q = halted;
      err_q  = err_code;
    end
  end

  task automatic push(input int kind, input int c, input logic [31:0] v);
    exp_q.push_back('{kind, c, v});
  endtask

  // R-type with rs=1, rt=2: load at t, exec at t+2, writeback at t+3.
  task automatic push_r(input int t, input logic [1:0] f, input logic [4:0] rd, input logic we);
    push(K_LOAD, t, 32'd0);
    push(K_EXEC, t + 2, {15'd0, f, 5'd1, 5'd2, rd});
    push(K_WB, t + 3, {30'd0, 1'b1, we});
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hold_reset(input logic rdy);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    imem_ready = rdy;
    for (int i = 0; i < 8; i++) prog[i] = 32'hFC00_0000;
  endtask

  task automatic release_reset();
    tick(1);
    rst = 1'b1;
    tick(1);
  endtask

  task automatic kick();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic chk_zero(input string name);
    chk(name, {imem_req, ir_load, rs_addr, rt_addr, rd_addr, rf_en, rf_we, alu_func,
               pc_en, busy, halted, err_code, instr_count}, 32'd0);
  endtask

  initial begin
    int k;
    #1 chk_zero("reset_outputs");

    // add $3,$1,$2 then HALT
    hold_reset(1'b1);
    prog[0] = 32'h0022_1820;
    release_reset();
    k = cyc;
    push_r(k + 1, 2'b00, 5'd3, 1'b1);
    push(K_LOAD, k + 5, 32'd0);
    push(K_HALT, k + 7, 32'd0);
    kick();
    tick(9);
    chk("add_count", instr_count, 32'd1);
    chk("add_halted", {busy, halted}, 32'd1);

    // sub, and, or, HALT
    hold_reset(1'b1);
    prog[0] = 32'h0022_1822;
    prog[1] = 32'h0022_1824;
    prog[2] = 32'h0022_1825;
    release_reset();
    k = cyc;
    push_r(k + 1, 2'b01, 5'd3, 1'b1);
    push_r(k + 5, 2'b10, 5'd3, 1'b1);
    push_r(k + 9, 2'b11, 5'd3, 1'b1);
    push(K_LOAD, k + 13, 32'd0);
    push(K_HALT, k + 15, 32'd0);
    kick();
    tick(20);
    chk("stream_count", instr_count, 32'd3);
    chk("stream_halted", halted, 32'd1);

    // NOP then add with rd=0, then HALT
    hold_reset(1'b1);
    prog[0] = 32'h0000_0000;
    prog[1] = 32'h0022_0020;
    release_reset();
    k = cyc;
    push(K_LOAD, k + 1, 32'd0);
    push(K_WB, k + 3, 32'd2);
    push_r(k + 4, 2'b00, 5'd0, 1'b0);
    push(K_LOAD, k + 8, 32'd0);
    push(K_HALT, k + 10, 32'd0);
    kick();
    tick(14);
    chk("nop_count", instr_count, 32'd2);

    // illegal lw, then start pulses must be ignored
    hold_reset(1'b1);
    prog[0] = 32'h8C22_0000;
    release_reset();
    k = cyc;
    push(K_LOAD, k + 1, 32'd0);
    push(K_ERR, k + 3, 32'd1);
    kick();
    tick(4);
    kick();
    tick(2);
    kick();
    tick(4);
    chk("ill_err_code", err_code, 32'd1);
    chk("ill_status", {imem_req, busy, halted}, 32'd0);
    chk("ill_count", instr_count, 32'd0);

    // fetch timeout: no ready for 15 cycles
    hold_reset(1'b0);
    prog[0] = 32'h0022_1820;
    release_reset();
    k = cyc;
    push(K_ERR, k + 16, 32'd2);
    kick();
    tick(20);
    chk("tmo_err_code", err_code, 32'd2);
    chk("tmo_busy", busy, 32'd0);

    // ready arriving on the 15th FETCH cycle wins over the timeout
    hold_reset(1'b0);
    prog[0] = 32'h0022_1820;
    release_reset();
    k = cyc;
    push_r(k + 15, 2'b00, 5'd3, 1'b1);
    push(K_LOAD, k + 19, 32'd0);
    push(K_HALT, k + 21, 32'd0);
    kick();
    tick(13);
    @(posedge clk);
    #1 imem_ready = 1'b1;
    tick(10);
    chk("late_ready_err", err_code, 32'd0);
    chk("late_ready_count", instr_count, 32'd1);

    // counter saturation: five adds on a 2-bit counter
    hold_reset(1'b1);
    for (int i = 0; i < 5; i++) prog[i] = 32'h0022_1820;
    release_reset();
    k = cyc;
    for (int i = 0; i < 5; i++) push_r(k + 1 + 4 * i, 2'b00, 5'd3, 1'b1);
    push(K_LOAD, k + 21, 32'd0);
    push(K_HALT, k + 23, 32'd0);
    kick();
    tick(26);
    chk("sat_count", instr_count, 32'd3);

    // reset asserted during EXEC aborts with no writeback strobes
    hold_reset(1'b1);
    prog[0] = 32'h0022_1820;
    release_reset();
    k = cyc;
    push(K_LOAD, k + 1, 32'd0);
    kick();
    tick(1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 chk_zero("midexec_reset");
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    k = cyc;
    push_r(k + 1, 2'b00, 5'd3, 1'b1);
    push(K_LOAD, k + 5, 32'd0);
    push(K_HALT, k + 7, 32'd0);
    kick();
    tick(9);
    chk("post_reset_count", instr_count, 32'd1);

    tick(2);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control sequencer for the single-cycle MIPS-style datapath (PC, PC adder, instruction ROM, register file, ALU control, ALU). It fetches an instruction through a request/ready handshake and decodes R-type add/sub/and/or, NOP and HALT. It then steps the datapath through execute and writeback with one-cycle strobes. It sits between the top-level start/status pins and the datapath enables, replacing the hard-wired always-enabled register file write.

## Interface
Parameters:
- FETCH_TMO, 15: max cycles FETCH waits for imem_ready before error (1..255)
- CNT_W, 16: width of retired-instruction counter

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (rst=0 resets immediately)
- start  in  1  begin execution; sampled only in IDLE
- instr  in  32  instruction word from instruction memory
- imem_ready  in  1  instr valid this cycle
- imem_req  out  1  fetch request, held high in FETCH
- ir_load  out  1  one-cycle pulse; IR captures instr on this edge
- rs_addr, rt_addr, rd_addr  out  5 each  IR[25:21], IR[20:16], IR[15:11], registered
- rf_en  out  1  register file read enable (EXEC)
- rf_we  out  1  register file write strobe (WB)
- alu_func  out  2  00 add, 01 sub, 10 and, 11 or
- pc_en  out  1  one-cycle PC advance strobe
- busy  out  1  high in any state except IDLE/HALT/ERR
- halted  out  1  high in HALT
- err_code  out  2  00 none, 01 illegal instruction, 10 fetch timeout; sticky
- instr_count  out  CNT_W  retired instructions, saturating

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT, ERR.
- IDLE: start=1 -> FETCH. Otherwise stay.
- FETCH: imem_req=1. Timer counts cycles in FETCH.
  - imem_ready=1 -> ir_load=1 this cycle, IR<=instr, -> DECODE.
  - Timer reaches FETCH_TMO with no ready -> ERR, err_code=10.
  - imem_ready on the same cycle as the timeout: ready wins.
- DECODE: opcode=IR[31:26], funct=IR[5:0].
  - IR==32'h0: NOP -> WB with rf_we suppressed.
  - opcode==6'h3F: -> HALT. No pc_en.
  - opcode==0 with funct 0x20/0x22/0x24/0x25: alu_func<=00/01/10/11 -> EXEC.
  - Any other instruction: -> ERR, err_code=01. No pc_en.
- EXEC: rf_en=1. alu_func stable. -> WB.
- WB: pc_en=1. rf_we=1 unless NOP or rd_addr==0. instr_count+1, saturating at 2^CNT_W-1. -> FETCH.
- HALT and ERR are terminal. start is ignored there; only rst exits.
- start outside IDLE is ignored.
- rs/rt/rd addresses and alu_func hold their values from DECODE until the next ir_load.

## Timing
- Reset (rst=0, asynchronous): state=IDLE. All outputs 0, including addresses, alu_func, err_code and instr_count. FETCH timer=0.
- Reset mid-instruction aborts immediately. No pc_en or rf_we is emitted.
- First FETCH is the cycle after start is sampled.
- Latency with imem_ready high on the first FETCH cycle:
  - R-type: 4 cycles (FETCH, DECODE, EXEC, WB).
  - NOP: 3 cycles (FETCH, DECODE, WB).
- Each added FETCH wait cycle adds 1 to latency.
- pc_en and rf_we are asserted in the same WB cycle. The datapath PC register and register file both update on that edge.
- ir_load is never high outside FETCH. rf_we and pc_en are never high outside WB.
- halted and err_code go high in the first cycle of HALT or ERR, respectively.
- The FETCH timer resets on every entry to FETCH.

## Test plan
- Reset, start=1, imem_ready tied 1, instr=0x00221820 (add $3,$1,$2) -> ir_load cycle 1, rf_en cycle 3 with alu_func=00, rd_addr=3, rf_we=pc_en=1 cycle 4, instr_count=1.
- Stream sub (0x00221822), and (0x00221824), or (0x00221825), then 0xFC000000 -> alu_func 01, 10, 11 in the respective EXEC cycles; halted=1; instr_count=3; no pc_en after the HALT decode.
- NOP 0x00000000, then add with rd=0 (0x00220020) -> NOP retires in 3 cycles with rf_we=0; add has rf_we=0 and pc_en=1; instr_count=2.
- Illegal 0x8C220000 (lw) -> ERR, err_code=01, busy=0; start pulses afterwards have no effect.
- imem_ready held 0 for 15 cycles -> ERR, err_code=10. Repeat with ready on cycle 15 -> normal DECODE.
- Assert rst=0 during EXEC -> all outputs 0 in the same cycle, no WB strobes. Release, start -> a clean 4-cycle add.
